// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and helpers (PC-1, PC-2, shift schedule, state enum).
// Used by both the encrypt and decrypt key paths.
package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // Left-shift amount applied going from round r-1 to round r (entry 0 = round 1).
    localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Key bit index n-1 feeds table entry n; the first entry lands in the result MSB.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = key[6'(PC1_TBL[i] - 1)];
        end
        return r;
    endfunction

    function automatic logic shift_two(input logic [3:0] idx);
        return SHIFT_SCHED[idx] == 2;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2 compression: 56-bit C/D register (C in the MSBs) to 48-bit round subkey.
// Pure wiring; the loop only unrolls the table into fixed connections.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] sk_o
);

    always_comb begin
        sk_o = '0;
        for (int i = 0; i < 48; i++) begin
            sk_o[6'(47 - i)] = cd_i[6'(56 - PC2_TBL[i])];
        end
    end

endmodule

// File: rtl/des_dec_key_stream.sv
// Iterative DES key scheduler emitting K16..K1 from a single C/D register.
// Optional DES_KEY_STREAM_FWD_EN adds a mode port selecting K1..K16 order instead.
module des_dec_key_stream
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] sk_out,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [3:0]  sk_round,
    output logic        sk_last,
`ifdef DES_KEY_STREAM_FWD_EN
    input  logic        mode,
`endif
    input  logic        clear
);

    ks_state_e   state_q;
    logic        key_ready_q;
    logic        sk_valid_q;
    logic        last_q;
    logic [55:0] cd_q;
    logic [55:0] cd_d;
    logic [3:0]  round_q;
    logic [3:0]  round_d;
    logic        last_d;
    logic [55:0] pc1_key;
`ifdef DES_KEY_STREAM_FWD_EN
    logic        fwd_q;
`endif

    assign pc1_key = pc1(key_in);

    // Undoing a left shift of round r+1 lands on C_r/D_r; 16 rounds sum to 28, so C16 = C0.
    always_comb begin
        cd_d    = {rotr28(cd_q[55:28], shift_two(round_q)),
                   rotr28(cd_q[27:0],  shift_two(round_q))};
        round_d = round_q - 4'd1;
        last_d  = (round_q == 4'd1);
`ifdef DES_KEY_STREAM_FWD_EN
        if (fwd_q) begin
            cd_d    = {rotl28(cd_q[55:28], shift_two(round_q + 4'd1)),
                       rotl28(cd_q[27:0],  shift_two(round_q + 4'd1))};
            round_d = round_q + 4'd1;
            last_d  = (round_q == 4'd14);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b1;
            sk_valid_q  <= 1'b0;
            last_q      <= 1'b0;
            cd_q        <= '0;
            round_q     <= '0;
`ifdef DES_KEY_STREAM_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else if (clear) begin
            // Abort leaves cd/round as they are; only the handshake state is dropped.
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b1;
            sk_valid_q  <= 1'b0;
            last_q      <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (key_valid) begin
                state_q     <= ST_RUN;
                key_ready_q <= 1'b0;
                sk_valid_q  <= 1'b1;
                last_q      <= 1'b0;
                cd_q        <= pc1_key;
                round_q     <= 4'd15;
`ifdef DES_KEY_STREAM_FWD_EN
                fwd_q       <= mode;
                if (mode) begin
                    cd_q    <= {rotl28(pc1_key[55:28], 1'b0), rotl28(pc1_key[27:0], 1'b0)};
                    round_q <= 4'd0;
                end
`endif
            end
        end else if (sk_ready) begin
            if (last_q) begin
                state_q     <= ST_IDLE;
                key_ready_q <= 1'b1;
                sk_valid_q  <= 1'b0;
                last_q      <= 1'b0;
            end else begin
                cd_q    <= cd_d;
                round_q <= round_d;
                last_q  <= last_d;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd_i (cd_q),
        .sk_o (sk_out)
    );

    assign key_ready = key_ready_q;
    assign sk_valid  = sk_valid_q;
    assign sk_round  = round_q;
    assign sk_last   = last_q;

endmodule

// File: tb/tb_des_dec_key_stream.sv
// Scoreboard bench for des_dec_key_stream against a table-driven DES key-schedule model.
module tb_des_dec_key_stream;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KNOWN_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KNOWN_K16 = 48'hCB3D8B0E17F5;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [47:0] sk_out;
    logic        sk_valid;
    logic        sk_ready;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        clear = 1'b0;
`ifdef DES_KEY_STREAM_FWD_EN
    logic        mode = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          hs_cnt = 0;
    logic        rdy_rand = 1'b0;
    exp_t        sb_q[$];
    logic [47:0] log_q[$];
    logic [47:0] exp_k [1:16];

    des_dec_key_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .sk_out    (sk_out),
        .sk_valid  (sk_valid),
        .sk_ready  (sk_ready),
        .sk_round  (sk_round),
        .sk_last   (sk_last),
`ifdef DES_KEY_STREAM_FWD_EN
        .mode      (mode),
`endif
        .clear     (clear)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] bitrev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63 - i];
        return r;
    endfunction

    // Standard DES schedule, bits numbered 1..64 from the MSB of k; K_r = PC2(C0D0 rotated left by the cumulative shift).
    task automatic compute_ks(input logic [63:0] k);
        logic c0 [28];
        logic d0 [28];
        int   tot;
        int   p;
        tot = 0;
        for (int i = 0; i < 28; i++) begin
            c0[i] = k[6'(64 - PC1[i])];
            d0[i] = k[6'(64 - PC1[i + 28])];
        end
        for (int r = 1; r <= 16; r++) begin
            tot += SHIFTS[r - 1];
            for (int j = 0; j < 48; j++) begin
                p = PC2[j];
                exp_k[r][6'(47 - j)] = (p <= 28) ? c0[(p - 1 + tot) % 28] : d0[(p - 29 + tot) % 28];
            end
        end
    endtask

    task automatic push_stream(input logic [63:0] k, input logic fwd);
        exp_t e;
        int   r;
        compute_ks(k);
        for (int i = 0; i < 16; i++) begin
            r      = fwd ? i + 1 : 16 - i;
            e.sk   = exp_k[r];
            e.rnd  = 4'(r - 1);
            e.last = fwd ? (r == 16) : (r == 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic send_key(input logic [63:0] k, input logic fwd);
        int n;
        n = 0;
        push_stream(k, fwd);
        while (key_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("key_ready_wait", 64'(n < 200), 64'd1);
        key_in    = bitrev64(k);
        key_valid = 1'b1;
`ifdef DES_KEY_STREAM_FWD_EN
        mode      = fwd;
`endif
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("first_valid_T+1", 64'(sk_valid), 64'd1);
        check("busy_key_ready", 64'(key_ready), 64'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || key_ready !== 1'b1) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("stream_drained", 64'(n < 2000), 64'd1);
    endtask

    task automatic check_known_log(input string tag, input logic [47:0] first, input logic [47:0] last);
        check({tag, "_count"}, 64'(log_q.size()), 64'd16);
        if (log_q.size() == 16) begin
            check({tag, "_first"}, 64'(log_q[0]), 64'(first));
            check({tag, "_last"}, 64'(log_q[15]), 64'(last));
        end
    endtask

    // Ready driver: always-ready or random backpressure.
    initial begin
        sk_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            sk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a transfer is seen at the negedge preceding the edge that completes it.
    initial begin
        logic        stall_prev;
        logic [47:0] stall_sk;
        logic [3:0]  stall_rnd;
        exp_t        e;
        stall_prev = 1'b0;
        stall_sk   = '0;
        stall_rnd  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && sk_valid)
                    check("stall_hold", 64'({sk_out, sk_round}), 64'({stall_sk, stall_rnd}));
                if (sk_valid && sk_ready && !clear) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_subkey", 64'(sk_out), 64'hDEAD_BEEF_0000);
                    end else begin
                        e = sb_q.pop_front();
                        check("subkey", 64'({sk_out, sk_round, sk_last}), 64'(e));
                    end
                    log_q.push_back(sk_out);
                    hs_cnt++;
                end
                stall_prev = sk_valid && !sk_ready && !clear;
                stall_sk   = sk_out;
                stall_rnd  = sk_round;
            end
        end
    end

    initial begin
        logic [63:0] ka;
        logic [63:0] kb;
        int          n;
        int          base;
        logic        acc;
        logic        rdy;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_sk_valid", 64'(sk_valid), 64'd0);
        check("rst_sk_out", 64'(sk_out), 64'd0);
        check("rst_sk_round", 64'(sk_round), 64'd0);
        check("rst_sk_last", 64'(sk_last), 64'd0);

        // Known key, no backpressure.
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        log_q.delete();
        send_key(KNOWN_KEY, 1'b0);
        wait_done();
        check_known_log("known", KNOWN_K16, KNOWN_K1);

        // Same key under random backpressure.
        rdy_rand = 1'b1;
        log_q.delete();
        send_key(KNOWN_KEY, 1'b0);
        wait_done();
        check_known_log("bp", KNOWN_K16, KNOWN_K1);

        for (int i = 0; i < 3; i++) begin
            send_key({$urandom, $urandom}, 1'b0);
            wait_done();
        end

        // Abort after five transfers.
        base = hs_cnt;
        send_key({$urandom, $urandom}, 1'b0);
        n = 0;
        while (hs_cnt < base + 5 && n < 500) begin
            @(posedge clk); n++;
        end
        check("abort_reach5", 64'(n < 500), 64'd1);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_sk_valid", 64'(sk_valid), 64'd0);
        check("abort_key_ready", 64'(key_ready), 64'd1);
        check("abort_remaining", 64'(sb_q.size()), 64'd11);
        sb_q.delete();
        log_q.delete();
        send_key(KNOWN_KEY, 1'b0);
        wait_done();
        check_known_log("post_abort", KNOWN_K16, KNOWN_K1);

        // Back-to-back keys with a held key_valid.
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        push_stream(ka, 1'b0);
        push_stream(kb, 1'b0);
        key_in    = bitrev64(ka);
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_in = bitrev64(kb);
        n      = 0;
        acc    = 1'b0;
        while (!acc && n < 40) begin
            rdy = key_ready;
            @(posedge clk); #1; n++;
            if (rdy) acc = 1'b1;
        end
        key_valid = 1'b0;
        check("b2b_accept_gap", 64'(n), 64'd17);
        wait_done();

        // Asynchronous reset mid-stream.
        send_key({$urandom, $urandom}, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_key_ready", 64'(key_ready), 64'd1);
        check("async_rst_sk_valid", 64'(sk_valid), 64'd0);
        check("async_rst_sk_out", 64'(sk_out), 64'd0);
        check("async_rst_sk_round", 64'(sk_round), 64'd0);
        check("async_rst_sk_last", 64'(sk_last), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        log_q.delete();
        send_key(KNOWN_KEY, 1'b0);
        wait_done();
        check_known_log("post_rst", KNOWN_K16, KNOWN_K1);

`ifdef DES_KEY_STREAM_FWD_EN
        log_q.delete();
        send_key(KNOWN_KEY, 1'b1);
        wait_done();
        check_known_log("fwd", KNOWN_K1, KNOWN_K16);
        rdy_rand = 1'b1;
        send_key({$urandom, $urandom}, 1'b1);
        wait_done();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
